// File: rtl/line_tracker_ctrl.sv
// line_tracker_ctrl: IR line-following steering controller (sync, debounce, FSM).
// Optional macro OBSTACLE_STOP_EN adds ultrasonic obstacle blocking.
module line_tracker_ctrl #(
  parameter int SAMPLE_DIV = 100_000,
  parameter int DEB_CNT    = 4,
  parameter int SEEK_TICKS = 500,
  parameter int BACK_TICKS = 300,
  parameter int OBST_NEAR  = 20,
  parameter int OBST_FAR   = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  sensor,
  input  logic [19:0] distance,
  output logic [2:0]  mode,
  output logic [2:0]  state_dbg,
  output logic        lost
);
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int CW = $clog2(DEB_CNT + 1);
  localparam logic [DW-1:0] L_DIV_END  = DW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] L_DEB      = CW'(DEB_CNT);
  localparam logic [19:0]   L_SEEK_END = 20'(SEEK_TICKS - 1);
  localparam logic [19:0]   L_BACK_END = 20'(BACK_TICKS - 1);

  localparam logic [2:0] M_STOP   = 3'd0;
  localparam logic [2:0] M_LEFT   = 3'd1;
  localparam logic [2:0] M_CENTER = 3'd2;
  localparam logic [2:0] M_RIGHT  = 3'd3;
  localparam logic [2:0] M_BACK   = 3'd4;
  localparam logic [2:0] M_RRIGHT = 3'd5;
  localparam logic [2:0] M_LLEFT  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRACK   = 3'd1,
    S_SEEK    = 3'd2,
    S_BACKUP  = 3'd3,
    S_HALT    = 3'd4,
    S_BLOCKED = 3'd5
  } state_t;

  logic [2:0]    r_s1, r_s2, r_cand, r_filt;
  logic [CW-1:0] r_dcnt, w_dcnt_nx;
  logic [DW-1:0] r_div;
  logic          w_tick;
  state_t        r_state, w_trk_state;
  logic [2:0]    r_mode, r_dir;
  logic [2:0]    w_map, w_trk_mode, w_trk_dir;
  logic          r_lost;
  logic [19:0]   r_cnt;
  logic          w_near, w_far;

  assign w_tick = (r_div == L_DIV_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1  <= 3'b000;
      r_s2  <= 3'b000;
      r_div <= '0;
    end else begin
      r_s1  <= sensor;
      r_s2  <= r_s1;
      r_div <= w_tick ? '0 : r_div + 1'b1;
    end
  end

  always_comb begin
    w_dcnt_nx = CW'(1);
    if (r_s2 == r_cand)
      w_dcnt_nx = (r_dcnt == L_DEB) ? r_dcnt : r_dcnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cand <= 3'b000;
      r_dcnt <= '0;
      r_filt <= 3'b000;
    end else if (w_tick) begin
      r_cand <= r_s2;
      r_dcnt <= w_dcnt_nx;
      if (w_dcnt_nx == L_DEB)
        r_filt <= r_s2;
    end
  end

  // 101 keeps the current mode and does not move last_dir
  always_comb begin
    w_map     = r_mode;
    w_trk_dir = r_dir;
    case (r_filt)
      3'b010, 3'b111: w_map = M_CENTER;
      3'b110: begin w_map = M_LLEFT;  w_trk_dir = M_LEFT;  end
      3'b100: begin w_map = M_LEFT;   w_trk_dir = M_LEFT;  end
      3'b011: begin w_map = M_RRIGHT; w_trk_dir = M_RIGHT; end
      3'b001: begin w_map = M_RIGHT;  w_trk_dir = M_RIGHT; end
      default: ;
    endcase
    w_trk_state = (r_filt == 3'b000) ? S_SEEK : S_TRACK;
    w_trk_mode  = (r_filt == 3'b000) ? r_dir : w_map;
  end

`ifdef OBSTACLE_STOP_EN
  assign w_near = (distance != 20'd0) && (distance < 20'(OBST_NEAR));
  assign w_far  = (distance == 20'd0) || (distance >= 20'(OBST_FAR));
`else
  logic w_unused_dist;
  assign w_unused_dist = ^distance;
  assign w_near = 1'b0;
  assign w_far  = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mode  <= M_STOP;
      r_lost  <= 1'b0;
      r_dir   <= M_LEFT;
      r_cnt   <= '0;
    end else if (!enable) begin
      r_state <= S_IDLE;
      r_mode  <= M_STOP;
      r_lost  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_tick) begin
      unique case (r_state)
        S_IDLE, S_TRACK: begin
          r_cnt <= '0;
          if (w_near && r_state == S_TRACK) begin
            r_state <= S_BLOCKED;
            r_mode  <= M_STOP;
          end else begin
            r_state <= w_trk_state;
            r_mode  <= w_trk_mode;
            r_dir   <= w_trk_dir;
          end
        end
        S_SEEK: begin
          if (w_near) begin
            r_state <= S_BLOCKED;
            r_mode  <= M_STOP;
            r_cnt   <= '0;
          end else if (r_filt != 3'b000) begin
            r_state <= S_TRACK;
            r_mode  <= w_map;
            r_dir   <= w_trk_dir;
            r_cnt   <= '0;
          end else if (r_cnt == L_SEEK_END) begin
            r_state <= S_BACKUP;
            r_mode  <= M_BACK;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BACKUP: begin
          if (r_filt != 3'b000) begin
            r_state <= S_TRACK;
            r_mode  <= w_map;
            r_dir   <= w_trk_dir;
            r_cnt   <= '0;
          end else if (r_cnt == L_BACK_END) begin
            r_state <= S_HALT;
            r_mode  <= M_STOP;
            r_lost  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HALT: begin
          r_mode <= M_STOP;
          r_lost <= 1'b1;
        end
        S_BLOCKED: begin
          if (w_far) begin
            r_state <= w_trk_state;
            r_mode  <= w_trk_mode;
            r_dir   <= w_trk_dir;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_mode  <= M_STOP;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign mode      = r_mode;
  assign state_dbg = r_state;
  assign lost      = r_lost;

endmodule

// File: tb/tb_line_tracker_ctrl.sv
// tb_line_tracker_ctrl: vector tables, corner sequences and random run
// against a tick-level reference model of the steering controller.
module tb_line_tracker_ctrl;
  localparam int SD   = 4;
  localparam int DEB  = 2;
  localparam int SEEK = 5;
  localparam int BACK = 3;
  localparam int NEAR = 20;
  localparam int FAR  = 25;
`ifdef OBSTACLE_STOP_EN
  localparam bit OBS = 1'b1;
`else
  localparam bit OBS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [2:0]  sensor = 3'b000;
  logic [19:0] distance = 20'd0;
  logic [2:0]  mode, state_dbg;
  logic        lost;

  always #5 clk = ~clk;

  line_tracker_ctrl #(
    .SAMPLE_DIV(SD), .DEB_CNT(DEB), .SEEK_TICKS(SEEK),
    .BACK_TICKS(BACK), .OBST_NEAR(NEAR), .OBST_FAR(FAR)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sensor(sensor),
    .distance(distance), .mode(mode), .state_dbg(state_dbg), .lost(lost)
  );

  int total = 0;
  int bad   = 0;
  int ph    = 0;

  typedef struct {
    bit       en;
    bit [2:0] s;
    int       d;
    int       m;
    int       st;
    int       l;
  } vec_t;

  vec_t tab[$];
  vec_t otab[$];

  function automatic vec_t v(bit en, bit [2:0] s, int d, int m, int st, int l);
    vec_t r;
    r.en = en; r.s = s; r.d = d; r.m = m; r.st = st; r.l = l;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk3(input string tag, input int m, input int st, input int l);
    chk({tag, ".mode"}, int'(mode), m);
    chk({tag, ".state"}, int'(state_dbg), st);
    chk({tag, ".lost"}, int'(lost), l);
  endtask

  task automatic wait_tick();
    do begin
      @(posedge clk);
      ph++;
    end while (ph % SD != 0);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    sensor = 3'b000;
    distance = 20'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ph = 0;
  endtask

  task automatic run_tab(input string nm, input vec_t t[$]);
    foreach (t[i]) begin
      enable = t[i].en;
      sensor = t[i].s;
      distance = 20'(t[i].d);
      wait_tick();
      chk3($sformatf("%s%0d", nm, i), t[i].m, t[i].st, t[i].l);
    end
  endtask

  // Reference model, one call per sample tick
  int m_state, m_mode, m_lost, m_dir, m_ent, m_tick, m_filt;
  bit [2:0] m_hist[$];

  task automatic m_reset();
    m_state = 0; m_mode = 0; m_lost = 0; m_dir = 1;
    m_ent = 0; m_tick = 0; m_filt = 0;
    m_hist.delete();
  endtask

  task automatic m_track(input int fb);
    m_ent = m_tick;
    if (fb == 0) begin
      m_state = 2;
      m_mode = m_dir;
    end else begin
      m_state = 1;
      case (fb)
        2, 7: m_mode = 2;
        6: m_mode = 6;
        4: m_mode = 1;
        3: m_mode = 5;
        1: m_mode = 3;
        default: ;
      endcase
      if (fb == 4 || fb == 6) m_dir = 1;
      if (fb == 1 || fb == 3) m_dir = 3;
    end
  endtask

  task automatic m_step(input bit en, input bit [2:0] s, input int d);
    int fb;
    bit same;
    bit near, far;
    fb = m_filt;
    m_tick++;
    m_hist.push_back(s);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    if (m_hist.size() == DEB) begin
      same = 1'b1;
      foreach (m_hist[k]) if (m_hist[k] != s) same = 1'b0;
      if (same) m_filt = s;
    end
    near = OBS && d != 0 && d < NEAR;
    far = d == 0 || d >= FAR;
    if (!en) begin
      m_state = 0; m_mode = 0; m_lost = 0;
    end else begin
      case (m_state)
        0: m_track(fb);
        1: if (near) begin m_state = 5; m_mode = 0; end
           else m_track(fb);
        2: if (near) begin m_state = 5; m_mode = 0; end
           else if (fb != 0) m_track(fb);
           else if (m_tick - m_ent == SEEK) begin
             m_state = 3; m_mode = 4; m_ent = m_tick;
           end
        3: if (fb != 0) m_track(fb);
           else if (m_tick - m_ent == BACK) begin
             m_state = 4; m_mode = 0; m_lost = 1;
           end
        4: ;
        5: if (far) m_track(fb);
        default: ;
      endcase
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dl[8];
    bit [2:0] cur_s;
    int cur_d;
    bit en;
    dl = '{0, 5, 19, 20, 22, 24, 25, 40};

    // en, sensor, dist -> mode, state, lost after that tick
    tab.push_back(v(0, 3'b010, 30, 0, 0, 0));
    tab.push_back(v(0, 3'b010, 30, 0, 0, 0));
    tab.push_back(v(1, 3'b010, 30, 2, 1, 0));
    tab.push_back(v(1, 3'b100, 30, 2, 1, 0));
    tab.push_back(v(1, 3'b010, 30, 2, 1, 0));
    tab.push_back(v(1, 3'b010, 30, 2, 1, 0));
    tab.push_back(v(1, 3'b110, 30, 2, 1, 0));
    tab.push_back(v(1, 3'b110, 30, 2, 1, 0));
    tab.push_back(v(1, 3'b000, 30, 6, 1, 0));
    tab.push_back(v(1, 3'b000, 30, 6, 1, 0));
    tab.push_back(v(1, 3'b000, 30, 1, 2, 0));
    tab.push_back(v(1, 3'b000, 30, 1, 2, 0));
    tab.push_back(v(1, 3'b010, 30, 1, 2, 0));
    tab.push_back(v(1, 3'b010, 30, 1, 2, 0));
    tab.push_back(v(1, 3'b010, 30, 2, 1, 0));
    tab.push_back(v(1, 3'b001, 30, 2, 1, 0));
    tab.push_back(v(1, 3'b001, 30, 2, 1, 0));
    tab.push_back(v(1, 3'b000, 30, 3, 1, 0));
    tab.push_back(v(1, 3'b000, 30, 3, 1, 0));
    for (int i = 0; i < 5; i++) tab.push_back(v(1, 3'b000, 30, 3, 2, 0));
    for (int i = 0; i < 3; i++) tab.push_back(v(1, 3'b000, 30, 4, 3, 0));
    tab.push_back(v(1, 3'b000, 30, 0, 4, 1));
    for (int i = 0; i < 3; i++) tab.push_back(v(1, 3'b010, 30, 0, 4, 1));

    otab.push_back(v(0, 3'b010, 30, 0, 0, 0));
    otab.push_back(v(0, 3'b010, 30, 0, 0, 0));
    otab.push_back(v(1, 3'b010, 30, 2, 1, 0));
    otab.push_back(v(1, 3'b010, 19, OBS ? 0 : 2, OBS ? 5 : 1, 0));
    otab.push_back(v(1, 3'b010, 22, OBS ? 0 : 2, OBS ? 5 : 1, 0));
    otab.push_back(v(1, 3'b010, 25, 2, 1, 0));
    otab.push_back(v(1, 3'b010, 20, 2, 1, 0));
    otab.push_back(v(1, 3'b010, 10, OBS ? 0 : 2, OBS ? 5 : 1, 0));
    otab.push_back(v(1, 3'b010, 0, 2, 1, 0));
    otab.push_back(v(1, 3'b010, 0, 2, 1, 0));

    do_reset();
    chk3("reset", 0, 0, 0);
    run_tab("vec", tab);

    // HALT exit on the very next clock after enable drops
    enable = 1'b0;
    @(posedge clk); ph++; #1;
    chk3("en_drop", 0, 0, 0);
    enable = 1'b1;
    wait_tick();
    chk3("en_rise", 2, 1, 0);

    sensor = 3'b001;
    wait_tick();
    chk3("pre_rst_a", 2, 1, 0);
    wait_tick();
    chk3("pre_rst_b", 2, 1, 0);
    wait_tick();
    chk3("pre_rst_c", 3, 1, 0);
    #2 reset = 1'b1;
    #1;
    chk3("async_rst", 0, 0, 0);

    do_reset();
    run_tab("obst", otab);

    do_reset();
    m_reset();
    cur_s = 3'b010;
    cur_d = 40;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) < 12) begin
        if ($urandom_range(99) < 40) cur_s = 3'b000;
        else cur_s = 3'($urandom_range(7));
      end
      if ($urandom_range(99) < 20) cur_d = dl[$urandom_range(7)];
      en = ($urandom_range(99) < 97);
      enable = en;
      sensor = cur_s;
      distance = 20'(cur_d);
      wait_tick();
      m_step(en, cur_s, cur_d);
      chk3($sformatf("rnd%0d", i), m_mode, m_state, m_lost);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
